// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline types and constants for the stall/flush sequencer.
package pipe_stall_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DSTALL   = 2'd1,
    IDISCARD = 2'd2
  } stall_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard compare: load in EX writes a register read by the instruction in ID.
module pipe_stall_ctrl_hazard_detect
  import pipe_stall_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic [REG_W-1:0] EX_rd,
  input  logic             EX_mem_read,
  output logic             load_use_c
);

  // x0 is never a real producer, so it cannot create a hazard.
  assign load_use_c = EX_mem_read && (EX_rd != REG_X0) &&
                      ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central load/flush/stall sequencer for the 5-stage pipeline, with a stall-cycle counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic [REG_W-1:0] EX_rd,
  input  logic             EX_mem_read,
  input  logic             EX_mispredict,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             load_pc,
  output logic             load_IF_ID,
  output logic             load_ID_EX,
  output logic             load_EX_MEM,
  output logic             load_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             MEM_EX_rdata_hazard,
  output logic [CNT_W-1:0] stall_cnt
);

  stall_state_t state, state_n;
  logic pend, pend_n;
  logic dstall, istall, lu, mp;
  logic ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb, fl_ifid, fl_idex, hz;

  pipe_stall_ctrl_hazard_detect u_hazard_detect (
    .ID_rs1      (ID_rs1),
    .ID_rs2      (ID_rs2),
    .EX_rd       (EX_rd),
    .EX_mem_read (EX_mem_read),
    .load_use_c  (lu)
  );

  assign dstall = dmem_req && !dmem_resp;
  assign istall = imem_req && !imem_resp;
  assign mp     = EX_mispredict || pend;

  // Next state and same-cycle stage enables.
  always_comb begin
    state_n  = state;
    pend_n   = pend;
    ld_pc    = 1'b0;
    ld_ifid  = 1'b0;
    ld_idex  = 1'b0;
    ld_exmem = 1'b0;
    ld_memwb = 1'b0;
    fl_ifid  = 1'b0;
    fl_idex  = 1'b0;
    hz       = 1'b0;
    case (state)
      RUN, DSTALL: begin
        if (dstall) begin
          hz      = 1'b1;
          pend_n  = mp;
          state_n = DSTALL;
        end else if (mp) begin
          {ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb} = 5'b11111;
          fl_ifid = 1'b1;
          fl_idex = 1'b1;
          pend_n  = 1'b0;
          state_n = istall ? IDISCARD : RUN;
        end else if (lu || istall) begin
          {ld_idex, ld_exmem, ld_memwb} = 3'b111;
          fl_idex = 1'b1;
          state_n = RUN;
        end else begin
          {ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb} = 5'b11111;
          state_n = RUN;
        end
      end
      IDISCARD: begin
        // Wrong-path fetch still in flight: its response must never reach IF/ID.
        pend_n = mp;
        if (dstall) begin
          hz = 1'b1;
        end else begin
          {ld_idex, ld_exmem, ld_memwb} = 3'b111;
          fl_idex = 1'b1;
          if (!istall) state_n = RUN;
        end
      end
      default: begin
        state_n = RUN;
        pend_n  = 1'b0;
      end
    endcase
  end

  assign load_pc             = reset_n && ld_pc;
  assign load_IF_ID          = reset_n && ld_ifid;
  assign load_ID_EX          = reset_n && ld_idex;
  assign load_EX_MEM         = reset_n && ld_exmem;
  assign load_MEM_WB         = reset_n && ld_memwb;
  assign flush_IF_ID         = reset_n && fl_ifid;
  assign flush_ID_EX         = reset_n && fl_idex;
  assign MEM_EX_rdata_hazard = reset_n && hz;

  // State, pending redirect and saturating stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      pend      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      if (!ld_pc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_pipe_stall_ctrl;

  typedef struct packed {
    logic [6:0]  ctl;
    logic        hz;
    logic [31:0] cnt;
    logic [2:0]  cnt_s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
  logic       EX_mem_read = 1'b0, EX_mispredict = 1'b0;
  logic       imem_req = 1'b0, imem_resp = 1'b0, dmem_req = 1'b0, dmem_resp = 1'b0;

  logic load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB;
  logic flush_IF_ID, flush_ID_EX, MEM_EX_rdata_hazard;
  logic [31:0] stall_cnt;
  logic s_load_pc, s_load_IF_ID, s_load_ID_EX, s_load_EX_MEM, s_load_MEM_WB;
  logic s_flush_IF_ID, s_flush_ID_EX, s_hz;
  logic [2:0] s_stall_cnt;

  pipe_stall_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .EX_rd(EX_rd),
    .EX_mem_read(EX_mem_read), .EX_mispredict(EX_mispredict), .imem_req(imem_req),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .load_pc(load_pc), .load_IF_ID(load_IF_ID), .load_ID_EX(load_ID_EX),
    .load_EX_MEM(load_EX_MEM), .load_MEM_WB(load_MEM_WB), .flush_IF_ID(flush_IF_ID),
    .flush_ID_EX(flush_ID_EX), .MEM_EX_rdata_hazard(MEM_EX_rdata_hazard), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  pipe_stall_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset_n(reset_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .EX_rd(EX_rd),
    .EX_mem_read(EX_mem_read), .EX_mispredict(EX_mispredict), .imem_req(imem_req),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .load_pc(s_load_pc), .load_IF_ID(s_load_IF_ID), .load_ID_EX(s_load_ID_EX),
    .load_EX_MEM(s_load_EX_MEM), .load_MEM_WB(s_load_MEM_WB), .flush_IF_ID(s_flush_IF_ID),
    .flush_ID_EX(s_flush_ID_EX), .MEM_EX_rdata_hazard(s_hz), .stall_cnt(s_stall_cnt)
  );

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a redirect owed, a wrong-path fetch to discard, and a stall-cycle tally.
  bit          m_discard = 1'b0;
  bit          m_pend = 1'b0;
  longint unsigned m_cnt = 0, m_cnt_s = 0;

  task automatic model_step(output exp_t e);
    bit ds, is, lu, fp;
    logic [4:0] l;
    logic [1:0] f;
    logic       h;
    ds = dmem_req && !dmem_resp;
    is = imem_req && !imem_resp;
    lu = EX_mem_read && (EX_rd != 5'd0) && ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));
    fp = EX_mispredict || m_pend;
    l = 5'b00000;
    f = 2'b00;
    h = 1'b0;
    if (!reset_n) begin
      m_discard = 1'b0; m_pend = 1'b0; m_cnt = 0; m_cnt_s = 0;
    end else if (ds) begin
      h = 1'b1; m_pend = fp;
    end else if (m_discard) begin
      l = 5'b00111; f = 2'b01; m_pend = fp;
      if (!is) m_discard = 1'b0;
    end else if (fp) begin
      l = 5'b11111; f = 2'b11; m_pend = 1'b0; m_discard = is;
    end else if (lu || is) begin
      l = 5'b00111; f = 2'b01;
    end else begin
      l = 5'b11111;
    end
    e.ctl   = {l, f};
    e.hz    = h;
    e.cnt   = 32'(m_cnt);
    e.cnt_s = 3'(m_cnt_s);
    if (reset_n && !l[4]) begin
      if (m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
      if (m_cnt_s < 7) m_cnt_s++;
    end
  endtask

  task automatic cyc(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic mr, input logic mp, input logic ir,
                     input logic irs, input logic dr, input logic drs);
    exp_t e;
    @(negedge clk);
    reset_n = rst; ID_rs1 = rs1; ID_rs2 = rs2; EX_rd = rd; EX_mem_read = mr;
    EX_mispredict = mp; imem_req = ir; imem_resp = irs; dmem_req = dr; dmem_resp = drs;
    model_step(e);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle against the queued expectation.
  initial begin : monitor
    exp_t e;
    logic [6:0] got, got_s;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e     = sb.pop_front();
        got   = {load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB, flush_IF_ID, flush_ID_EX};
        got_s = {s_load_pc, s_load_IF_ID, s_load_ID_EX, s_load_EX_MEM, s_load_MEM_WB,
                 s_flush_IF_ID, s_flush_ID_EX};
        checks++;
        if (got !== e.ctl) begin
          errors++;
          $display("FAIL ctl t=%0t got=%b exp=%b", $time, got, e.ctl);
        end
        checks++;
        if (MEM_EX_rdata_hazard !== e.hz) begin
          errors++;
          $display("FAIL hazard t=%0t got=%b exp=%b", $time, MEM_EX_rdata_hazard, e.hz);
        end
        checks++;
        if (stall_cnt !== e.cnt) begin
          errors++;
          $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, e.cnt);
        end
        checks++;
        if ({got_s, s_hz, s_stall_cnt} !== {e.ctl, e.hz, e.cnt_s}) begin
          errors++;
          $display("FAIL sat_inst t=%0t got=%b/%b/%0d exp=%b/%b/%0d", $time,
                   got_s, s_hz, s_stall_cnt, e.ctl, e.hz, e.cnt_s);
        end
      end
    end
  end

  initial begin : driver
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Load-use on rs2: one bubble.
    cyc(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    // Load to x0 never hazards.
    cyc(1'b1, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    // Four-cycle D-miss, then response.
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'd7, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 5'd7, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    // Mispredict while D-stalled: flush held until the response cycle.
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    // Mispredict with I-miss outstanding: stale response three cycles later is dropped.
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Mispredict together with load-use: flush wins.
    cyc(1'b1, 5'd6, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    // Long I-miss drives the narrow counter into saturation.
    for (int i = 0; i < 12; i++) cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    // Reset asserted in the middle of a D-stall with a redirect pending.
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    // Randomized traffic with a small register range to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) != 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 5),
          ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4));
    end
    @(negedge clk);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
